// File: rtl/delay_timer_if.sv
// Handshake bundle between the control FSM (master) and the delay timer (slave).
// Carries the start/enable controls, the delay operand and the timer status.
interface delay_timer_if #(
    parameter int WIDTH = 16
);
    logic             start_delay_counter;
    logic             enable_delay_counter;
    logic             pause_mode;
    logic [WIDTH-1:0] delay_value;
    logic             delay_done;
    logic             delay_busy;
    logic [WIDTH-1:0] delay_remaining;

    modport master (
        output start_delay_counter,
        output enable_delay_counter,
        output pause_mode,
        output delay_value,
        input  delay_done,
        input  delay_busy,
        input  delay_remaining
    );

    modport slave (
        input  start_delay_counter,
        input  enable_delay_counter,
        input  pause_mode,
        input  delay_value,
        output delay_done,
        output delay_busy,
        output delay_remaining
    );
endinterface

// File: rtl/delay_timer.sv
// Programmable delay counter pacing MOVR/MOVRHS/PAUSE: counts delay_value
// prescaled ticks, then holds delay_done until the next start or reset.
module delay_timer #(
    parameter int WIDTH    = 16,
    parameter int PRESCALE = 50000
) (
    input logic          clk,
    input logic          rst,
    delay_timer_if.slave bus
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        DONE
    } state_t;

    state_t           r_state;
    logic [PW-1:0]    r_prescaler;
    logic [WIDTH-1:0] r_remaining;
    logic             r_mode;
    logic             r_done;
    logic             r_busy;

    logic             w_cntEn;
    logic             w_tick;

    // Pause delays run free; step delays advance only while the FSM enables them.
    assign w_cntEn = r_mode | bus.enable_delay_counter;
    assign w_tick  = w_cntEn && (r_prescaler == PW'(PRESCALE - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_prescaler <= '0;
            r_remaining <= '0;
            r_mode      <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
        end else if (bus.start_delay_counter) begin
            r_remaining <= bus.delay_value;
            r_prescaler <= '0;
            r_mode      <= bus.pause_mode;
            if (bus.delay_value == '0) begin
                r_state <= DONE;
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
            end else begin
                r_state <= COUNT;
                r_done  <= 1'b0;
                r_busy  <= 1'b1;
            end
        end else begin
            case (r_state)
                COUNT: begin
                    if (w_tick) begin
                        r_prescaler <= '0;
                        r_remaining <= r_remaining - WIDTH'(1);
                        if (r_remaining == WIDTH'(1)) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end else if (w_cntEn) begin
                        r_prescaler <= r_prescaler + PW'(1);
                    end
                end
                DONE: begin
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.delay_done      = r_done;
    assign bus.delay_busy      = r_busy;
    assign bus.delay_remaining = r_remaining;
endmodule

// File: tb/tb_delay_timer.sv
// Directed bench for delay_timer with PRESCALE=4; expected values are
// hand-computed cycle counts relative to the start edge E0.
module tb_delay_timer;
    localparam int WIDTH    = 16;
    localparam int PRESCALE = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   compared   = 0;
    int   mismatched = 0;

    delay_timer_if #(.WIDTH(WIDTH)) bus ();

    delay_timer #(
        .WIDTH   (WIDTH),
        .PRESCALE(PRESCALE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic checkState(input string tag, input int expDone, input int expBusy, input int expRem);
        checkOutput({tag, ".done"}, 32'(bus.delay_done), expDone);
        checkOutput({tag, ".busy"}, 32'(bus.delay_busy), expBusy);
        checkOutput({tag, ".rem"},  32'(bus.delay_remaining), expRem);
    endtask

    task automatic applyStimulus(input logic start, input logic enable, input logic pause, input int value);
        bus.start_delay_counter  = start;
        bus.enable_delay_counter = enable;
        bus.pause_mode           = pause;
        bus.delay_value          = WIDTH'(value);
    endtask

    // Advance n rising edges and settle 1 ns past the last one.
    task automatic waitEdges(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Pulse start across one edge (E0); returns 1 ns after E0.
    task automatic startDelay(input logic enable, input logic pause, input int value);
        applyStimulus(1'b1, enable, pause, value);
        waitEdges(1);
        applyStimulus(1'b0, enable, pause, value);
    endtask

    initial begin
        applyStimulus(1'b0, 1'b0, 1'b0, 0);
        waitEdges(2);
        checkState("reset", 0, 0, 0);
        #2 rst = 1'b0;

        // Basic count: value 3, enable held
        startDelay(1'b1, 1'b0, 3);
        checkState("basic.E0", 0, 1, 3);
        waitEdges(3);
        checkState("basic.E3", 0, 1, 3);
        waitEdges(1);
        checkState("basic.E4", 0, 1, 2);
        waitEdges(4);
        checkState("basic.E8", 0, 1, 1);
        waitEdges(3);
        checkState("basic.E11", 0, 1, 1);
        waitEdges(1);
        checkState("basic.E12", 1, 0, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 0);
        waitEdges(3);
        checkState("basic.hold", 1, 0, 0);

        // Enable gap of 5 cycles extends the delay to 17
        startDelay(1'b1, 1'b0, 3);
        checkState("gap.E0", 0, 1, 3);
        waitEdges(2);
        applyStimulus(1'b0, 1'b0, 1'b0, 3);
        waitEdges(5);
        checkState("gap.E7", 0, 1, 3);
        applyStimulus(1'b0, 1'b1, 1'b0, 3);
        waitEdges(2);
        checkState("gap.E9", 0, 1, 2);
        waitEdges(7);
        checkState("gap.E16", 0, 1, 1);
        waitEdges(1);
        checkState("gap.E17", 1, 0, 0);

        // Pause mode counts with enable low
        startDelay(1'b0, 1'b1, 2);
        applyStimulus(1'b0, 1'b0, 1'b0, 2);
        checkState("pause.E0", 0, 1, 2);
        waitEdges(7);
        checkState("pause.E7", 0, 1, 1);
        waitEdges(1);
        checkState("pause.E8", 1, 0, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 0);
        waitEdges(2);
        checkState("pause.doneHold", 1, 0, 0);
        startDelay(1'b0, 1'b0, 5);
        checkState("pause.restart", 0, 1, 5);
        waitEdges(6);
        checkState("pause.noEnable", 0, 1, 5);

        // Zero delay goes straight to DONE
        startDelay(1'b1, 1'b0, 0);
        checkState("zero.E1", 1, 0, 0);
        waitEdges(2);
        checkState("zero.E3", 1, 0, 0);

        // Restart at E0+6 with value 1 during a value-5 count
        startDelay(1'b1, 1'b0, 5);
        waitEdges(5);
        checkState("restart.E5", 0, 1, 4);
        startDelay(1'b1, 1'b0, 1);
        checkState("restart.E6", 0, 1, 1);
        waitEdges(3);
        checkState("restart.E9", 0, 1, 1);
        waitEdges(1);
        checkState("restart.E10", 1, 0, 0);

        // Asynchronous reset mid-count, between edges
        startDelay(1'b1, 1'b0, 4);
        waitEdges(5);
        checkState("areset.before", 0, 1, 3);
        #2 rst = 1'b1;
        #1;
        checkState("areset.during", 0, 0, 0);
        #2 rst = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b1, 7);
        waitEdges(10);
        checkState("areset.idle", 0, 0, 0);
        startDelay(1'b1, 1'b0, 1);
        checkState("areset.start", 0, 1, 1);
        waitEdges(4);
        checkState("areset.done", 1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
